// File: rtl/data_mem_ctrl_if.sv
// Signal bundle between the data memory controller, the core load/store stage and the memory port.
// The master modport is the controller's view; the slave modport is the environment (core + memory).
interface data_mem_ctrl_if;
    logic        i_core_rd_en;
    logic        i_core_wr_en;
    logic [31:0] i_core_addr;
    logic [31:0] i_core_wdata;
    logic [3:0]  i_core_size;
    logic        o_core_ready;
    logic [31:0] o_core_rdata;
    logic        o_core_err;

    logic        o_mem_req;
    logic        o_mem_we;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        i_mem_gnt;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;

    modport master (
        input  i_core_rd_en, i_core_wr_en, i_core_addr, i_core_wdata, i_core_size,
        output o_core_ready, o_core_rdata, o_core_err,
        output o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
        input  i_mem_gnt, i_mem_rvalid, i_mem_rdata
    );

    modport slave (
        output i_core_rd_en, i_core_wr_en, i_core_addr, i_core_wdata, i_core_size,
        input  o_core_ready, o_core_rdata, o_core_err,
        input  o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
        output i_mem_gnt, i_mem_rvalid, i_mem_rdata
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Single-outstanding load/store controller between the core and a req/gnt/rvalid memory port.
// Handles lane alignment, legality checks and a grant/response timeout.
module data_mem_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input logic             clk,
    input logic             rst,
    data_mem_ctrl_if.master bus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  tmo_cnt;
    logic [7:0]  tmo_cnt_nxt;
    logic        err_q;
    logic        err_nxt;

    logic        is_rd_q;
    logic [1:0]  off_q;
    logic [3:0]  size_q;
    logic        mem_we_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] rdata_q;

    logic        core_req;
    logic        size_ok;
    logic        req_legal;
    logic        load_req;
    logic        rd_capture;
    logic        rd_clear;
    logic [31:0] rd_shifted;
    logic [31:0] rd_mask;

    assign core_req = bus.i_core_rd_en | bus.i_core_wr_en;

    // Only naturally aligned byte, half and word accesses are legal.
    always_comb begin
        case (bus.i_core_size)
            4'b0001: size_ok = 1'b1;
            4'b0011: size_ok = ~bus.i_core_addr[0];
            4'b1111: size_ok = (bus.i_core_addr[1:0] == 2'b00);
            default: size_ok = 1'b0;
        endcase
    end

    assign req_legal = size_ok & ~(bus.i_core_rd_en & bus.i_core_wr_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_cnt_nxt;
            err_q   <= err_nxt;
        end
    end

    // Grant and response win over the timeout on the last allowed cycle.
    always_comb begin
        state_nxt   = state;
        tmo_cnt_nxt = tmo_cnt;
        err_nxt     = err_q;
        load_req    = 1'b0;
        rd_capture  = 1'b0;
        rd_clear    = 1'b0;
        case (state)
            IDLE: begin
                tmo_cnt_nxt = '0;
                if (core_req) begin
                    if (req_legal) begin
                        load_req  = 1'b1;
                        err_nxt   = 1'b0;
                        state_nxt = REQ;
                    end else begin
                        err_nxt   = 1'b1;
                        rd_clear  = bus.i_core_rd_en;
                        state_nxt = DONE;
                    end
                end
            end
            REQ: begin
                if (bus.i_mem_gnt) begin
                    tmo_cnt_nxt = '0;
                    state_nxt   = WAIT;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_cnt_nxt = '0;
                    err_nxt     = 1'b1;
                    rd_clear    = is_rd_q;
                    state_nxt   = DONE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 8'd1;
                end
            end
            WAIT: begin
                if (bus.i_mem_rvalid) begin
                    tmo_cnt_nxt = '0;
                    err_nxt     = 1'b0;
                    rd_capture  = is_rd_q;
                    state_nxt   = DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_cnt_nxt = '0;
                    err_nxt     = 1'b1;
                    rd_clear    = is_rd_q;
                    state_nxt   = DONE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 8'd1;
                end
            end
            DONE: begin
                tmo_cnt_nxt = '0;
                state_nxt   = IDLE;
            end
            default: begin
                tmo_cnt_nxt = '0;
                state_nxt   = IDLE;
            end
        endcase
    end

    assign rd_shifted = bus.i_mem_rdata >> {off_q, 3'b000};
    assign rd_mask    = {{8{size_q[3]}}, {8{size_q[2]}}, {8{size_q[1]}}, {8{size_q[0]}}};

    // Memory-side fields are only written when a legal request is accepted, so they hold afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_rd_q     <= 1'b0;
            off_q       <= 2'b00;
            size_q      <= 4'b0000;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            if (load_req) begin
                is_rd_q     <= bus.i_core_rd_en;
                off_q       <= bus.i_core_addr[1:0];
                size_q      <= bus.i_core_size;
                mem_we_q    <= bus.i_core_wr_en;
                mem_be_q    <= bus.i_core_size << bus.i_core_addr[1:0];
                mem_addr_q  <= {bus.i_core_addr[31:2], 2'b00};
                mem_wdata_q <= bus.i_core_wdata << {bus.i_core_addr[1:0], 3'b000};
            end
            if (rd_capture) begin
                rdata_q <= rd_shifted & rd_mask;
            end else if (rd_clear) begin
                rdata_q <= '0;
            end
        end
    end

    assign bus.o_mem_req    = (state == REQ);
    assign bus.o_mem_we     = mem_we_q;
    assign bus.o_mem_be     = mem_be_q;
    assign bus.o_mem_addr   = mem_addr_q;
    assign bus.o_mem_wdata  = mem_wdata_q;

    assign bus.o_core_ready = (state == IDLE) ? ~core_req : (state == DONE);
    assign bus.o_core_err   = (state == DONE) & err_q;
    assign bus.o_core_rdata = rdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: hand-computed vectors, randomized transactions against
// a transaction-level model, and an asynchronous reset taken in the middle of a read.
module tb_data_mem_ctrl;

    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    data_mem_ctrl_if bus ();

    data_mem_ctrl #(.TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // One core access plus how the memory answers it and what must come back.
    // g = cycles o_mem_req waits before grant, r = cycles in WAIT before rvalid.
    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  size;
        int          g;
        int          r;
        logic [31:0] memdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        int          req_last;
        int          ready_c;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } txn_t;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_rdata;
    txn_t        vec [14];

    function automatic txn_t mkVec(input logic rd, input logic wr, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [3:0] size,
                                   input int g, input int r, input logic [31:0] memdata,
                                   input logic [3:0] be, input logic [31:0] maddr,
                                   input logic [31:0] mwdata, input int req_last,
                                   input int ready_c, input logic err, input logic [31:0] rdata);
        txn_t t;
        t.rd = rd; t.wr = wr; t.addr = addr; t.wdata = wdata; t.size = size;
        t.g = g; t.r = r; t.memdata = memdata;
        t.exp_be = be; t.exp_addr = maddr; t.exp_wdata = mwdata;
        t.req_last = req_last; t.ready_c = ready_c; t.exp_err = err; t.exp_rdata = rdata;
        return t;
    endfunction

    // Reference: what a single access should look like, from the legality, alignment and timeout rules.
    function automatic txn_t modelTxn(input logic rd, input logic wr, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic [3:0] size,
                                      input int g, input int r, input logic [31:0] memdata,
                                      input logic [31:0] prev_rdata);
        txn_t        t;
        int          off;
        logic        legal;
        logic [7:0]  wide_be;
        logic [31:0] mask;
        off   = int'(addr % 4);
        legal = !(rd && wr) && ((size == 4'b0001) ||
                                (size == 4'b0011 && (off % 2) == 0) ||
                                (size == 4'b1111 && off == 0));
        wide_be = {4'b0000, size} << off;
        case (size)
            4'b0001: mask = 32'h0000_00FF;
            4'b0011: mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        t = mkVec(rd, wr, addr, wdata, size, g, r, memdata, wide_be[3:0],
                  (addr / 4) * 4, wdata << (8 * off), 0, 0, 1'b0, prev_rdata);
        if (!legal) begin
            t.req_last = 0;
            t.ready_c  = 1;
            t.exp_err  = 1'b1;
        end else if (g >= TMO) begin
            t.req_last = TMO;
            t.ready_c  = 1 + TMO;
            t.exp_err  = 1'b1;
        end else if (r >= TMO) begin
            t.req_last = 1 + g;
            t.ready_c  = 2 + g + TMO;
            t.exp_err  = 1'b1;
        end else begin
            t.req_last = 1 + g;
            t.ready_c  = 3 + g + r;
            t.exp_err  = 1'b0;
        end
        if (rd) t.exp_rdata = t.exp_err ? 32'h0 : ((memdata >> (8 * off)) & mask);
        return t;
    endfunction

    task automatic checkOutput(input string name, input int idx, input int cyc,
                               input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s txn=%0d cyc=%0d got=0x%08h want=0x%08h", name, idx, cyc, act, exp);
        end
    endtask

    task automatic driveIdle();
        bus.i_core_rd_en  = 1'b0;
        bus.i_core_wr_en  = 1'b0;
        bus.i_core_addr   = '0;
        bus.i_core_wdata  = '0;
        bus.i_core_size   = '0;
        bus.i_mem_gnt     = 1'b0;
        bus.i_mem_rvalid  = 1'b0;
        bus.i_mem_rdata   = '0;
    endtask

    // Cycle 0 is the IDLE cycle in which the request is first presented.
    task automatic applyStimulus(input txn_t t, input int idx);
        int   gnt_c;
        int   rv_c;
        int   last_c;
        logic exp_req;
        gnt_c  = (t.req_last > 0) ? 1 + t.g : -1;
        rv_c   = (t.req_last > 0) ? 2 + t.g + t.r : -1;
        last_c = t.ready_c;
        if (gnt_c > last_c) last_c = gnt_c;
        if (rv_c > last_c) last_c = rv_c;
        last_c = last_c + 1;
        for (int c = 0; c <= last_c; c++) begin
            @(posedge clk);
            #1;
            if (c <= t.ready_c) begin
                bus.i_core_rd_en = t.rd;
                bus.i_core_wr_en = t.wr;
                bus.i_core_addr  = t.addr;
                bus.i_core_wdata = t.wdata;
                bus.i_core_size  = t.size;
            end else begin
                bus.i_core_rd_en = 1'b0;
                bus.i_core_wr_en = 1'b0;
                bus.i_core_addr  = $urandom;
                bus.i_core_wdata = $urandom;
                bus.i_core_size  = 4'($urandom);
            end
            bus.i_mem_gnt    = (c == gnt_c);
            bus.i_mem_rvalid = (c == rv_c);
            bus.i_mem_rdata  = (c == rv_c) ? t.memdata : $urandom;
            @(negedge clk);
            exp_req = (t.req_last > 0) && (c >= 1) && (c <= t.req_last);
            checkOutput("mem_req", idx, c, 32'(bus.o_mem_req), 32'(exp_req));
            if (exp_req) begin
                checkOutput("mem_be", idx, c, 32'(bus.o_mem_be), 32'(t.exp_be));
                checkOutput("mem_addr", idx, c, bus.o_mem_addr, t.exp_addr);
                checkOutput("mem_we", idx, c, 32'(bus.o_mem_we), 32'(t.wr));
                if (t.wr) checkOutput("mem_wdata", idx, c, bus.o_mem_wdata, t.exp_wdata);
            end
            checkOutput("core_ready", idx, c, 32'(bus.o_core_ready), 32'(c >= t.ready_c));
            checkOutput("core_err", idx, c, 32'(bus.o_core_err),
                        32'((c == t.ready_c) ? t.exp_err : 1'b0));
            if (c >= t.ready_c) checkOutput("core_rdata", idx, c, bus.o_core_rdata, t.exp_rdata);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        txn_t        t;
        logic        rd;
        logic [3:0]  size;
        logic [31:0] addr;
        int          sel;
        int          g;
        int          r;

        // rd, wr, addr, wdata, size, g, r, memdata | be, maddr, mwdata, req_last, ready, err, rdata
        vec[0]  = mkVec(1, 0, 32'h100, 32'h0, 4'hF, 0, 0, 32'hCAFEBABE,
                        4'hF, 32'h100, 32'h0, 1, 3, 0, 32'hCAFEBABE);
        vec[1]  = mkVec(0, 1, 32'h203, 32'h000000A5, 4'h1, 0, 0, 32'h0,
                        4'h8, 32'h200, 32'hA5000000, 1, 3, 0, 32'hCAFEBABE);
        vec[2]  = mkVec(1, 0, 32'h102, 32'h0, 4'h3, 0, 0, 32'h1234ABCD,
                        4'hC, 32'h100, 32'h0, 1, 3, 0, 32'h00001234);
        vec[3]  = mkVec(1, 0, 32'h101, 32'h0, 4'hF, 0, 0, 32'h0,
                        4'h0, 32'h0, 32'h0, 0, 1, 1, 32'h0);
        vec[4]  = mkVec(1, 1, 32'h40, 32'h0, 4'hF, 0, 0, 32'h0,
                        4'h0, 32'h0, 32'h0, 0, 1, 1, 32'h0);
        vec[5]  = mkVec(1, 0, 32'h300, 32'h0, 4'hF, 20, 0, 32'hDEADBEEF,
                        4'hF, 32'h300, 32'h0, 8, 9, 1, 32'h0);
        vec[6]  = mkVec(1, 0, 32'h7, 32'h0, 4'h1, 3, 4, 32'h89ABCDEF,
                        4'h8, 32'h4, 32'h0, 4, 10, 0, 32'h00000089);
        vec[7]  = mkVec(0, 1, 32'h12, 32'h0000BEEF, 4'h3, 1, 8, 32'h0,
                        4'hC, 32'h10, 32'hBEEF0000, 2, 11, 1, 32'h00000089);
        vec[8]  = mkVec(1, 0, 32'h1, 32'h0, 4'h1, 0, 7, 32'h00005A00,
                        4'h2, 32'h0, 32'h0, 1, 10, 0, 32'h0000005A);
        vec[9]  = mkVec(1, 0, 32'h20, 32'h0, 4'hF, 7, 0, 32'h11223344,
                        4'hF, 32'h20, 32'h0, 8, 10, 0, 32'h11223344);
        vec[10] = mkVec(0, 1, 32'h0, 32'h55, 4'h5, 0, 0, 32'h0,
                        4'h0, 32'h0, 32'h0, 0, 1, 1, 32'h11223344);
        vec[11] = mkVec(0, 1, 32'h44, 32'h01020304, 4'hF, 2, 1, 32'h0,
                        4'hF, 32'h44, 32'h01020304, 3, 6, 0, 32'h11223344);
        vec[12] = mkVec(1, 0, 32'h3, 32'h0, 4'h3, 0, 0, 32'hFFFFFFFF,
                        4'h0, 32'h0, 32'h0, 0, 1, 1, 32'h0);
        vec[13] = mkVec(0, 1, 32'h2, 32'h1234ABCD, 4'h3, 0, 0, 32'h0,
                        4'hC, 32'h0, 32'hABCD0000, 1, 3, 0, 32'h0);

        rst = 1'b1;
        driveIdle();
        #12;
        checkOutput("rst_ready", 0, 0, 32'(bus.o_core_ready), 32'h1);
        checkOutput("rst_mem_req", 0, 0, 32'(bus.o_mem_req), 32'h0);
        checkOutput("rst_mem_we", 0, 0, 32'(bus.o_mem_we), 32'h0);
        checkOutput("rst_mem_be", 0, 0, 32'(bus.o_mem_be), 32'h0);
        checkOutput("rst_mem_addr", 0, 0, bus.o_mem_addr, 32'h0);
        checkOutput("rst_mem_wdata", 0, 0, bus.o_mem_wdata, 32'h0);
        checkOutput("rst_rdata", 0, 0, bus.o_core_rdata, 32'h0);
        checkOutput("rst_err", 0, 0, 32'(bus.o_core_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_rdata = 32'h0;

        $display("[TB] directed vectors");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vec[i], i);
            model_rdata = vec[i].exp_rdata;
        end

        $display("[TB] randomized transactions");
        for (int n = 0; n < 200; n++) begin
            rd  = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 9));
            if (sel < 3)      size = 4'b0001;
            else if (sel < 6) size = 4'b0011;
            else if (sel < 9) size = 4'b1111;
            else              size = 4'($urandom);
            addr = $urandom;
            if ($urandom_range(0, 9) < 7) begin
                if (size == 4'b0011) addr[0] = 1'b0;
                if (size == 4'b1111) addr[1:0] = 2'b00;
            end
            g = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 11)) : int'($urandom_range(0, 2));
            r = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 11)) : int'($urandom_range(0, 2));
            t = modelTxn(rd, !rd, addr, $urandom, size, g, r, $urandom, model_rdata);
            applyStimulus(t, 100 + n);
            model_rdata = t.exp_rdata;
        end

        $display("[TB] reset while waiting for a read response");
        @(posedge clk);
        #1;
        bus.i_core_rd_en = 1'b1;
        bus.i_core_addr  = 32'h80;
        bus.i_core_size  = 4'hF;
        @(posedge clk);
        #1;
        bus.i_mem_gnt = 1'b1;
        @(posedge clk);
        #1;
        bus.i_mem_gnt = 1'b0;
        #1;
        checkOutput("wait_mem_req", 900, 2, 32'(bus.o_mem_req), 32'h0);
        checkOutput("wait_mem_be", 900, 2, 32'(bus.o_mem_be), 32'hF);
        checkOutput("wait_ready", 900, 2, 32'(bus.o_core_ready), 32'h0);
        #1;
        rst = 1'b1;
        bus.i_core_rd_en = 1'b0;
        #1;
        checkOutput("arst_mem_req", 900, 2, 32'(bus.o_mem_req), 32'h0);
        checkOutput("arst_ready", 900, 2, 32'(bus.o_core_ready), 32'h1);
        checkOutput("arst_err", 900, 2, 32'(bus.o_core_err), 32'h0);
        checkOutput("arst_mem_be", 900, 2, 32'(bus.o_mem_be), 32'h0);
        checkOutput("arst_mem_addr", 900, 2, bus.o_mem_addr, 32'h0);
        checkOutput("arst_rdata", 900, 2, bus.o_core_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = 32'hFFFFFFFF;
        @(negedge clk);
        checkOutput("late_rv_ready", 900, 3, 32'(bus.o_core_ready), 32'h1);
        checkOutput("late_rv_mem_req", 900, 3, 32'(bus.o_mem_req), 32'h0);
        @(posedge clk);
        #1;
        bus.i_mem_rvalid = 1'b0;
        @(negedge clk);
        checkOutput("late_rv_rdata", 900, 4, bus.o_core_rdata, 32'h0);
        checkOutput("late_rv_err", 900, 4, 32'(bus.o_core_err), 32'h0);
        checkOutput("late_rv_ready2", 900, 4, 32'(bus.o_core_ready), 32'h1);
        model_rdata = 32'h0;

        t = modelTxn(1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 0, 0, 32'h600DF00D, model_rdata);
        applyStimulus(t, 901);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 64, sets the maximum cycles spent waiting in REQ or WAIT before the access is aborted; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 i_core_rd_en  input  1  core load request, held stable until o_core_ready.
REQ-005 i_core_wr_en  input  1  core store request, held stable until o_core_ready.
REQ-006 i_core_addr  input  32  byte address.
REQ-007 i_core_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-008 i_core_size  input  4  unshifted lane mask: 0001 byte, 0011 half, 1111 word; other codes illegal.
REQ-009 o_core_ready  output  1  access complete / controller free; core stage advances on 1.
REQ-010 o_core_rdata  output  32  load data, right-aligned, zero-filled above access size.
REQ-011 o_core_err  output  1  one-cycle pulse with o_core_ready on a failed access.
REQ-012 o_mem_req  output  1  memory request valid.
REQ-013 o_mem_we  output  1  1 write, 0 read.
REQ-014 o_mem_be  output  4  byte lanes, i_core_size shifted left by addr[1:0].
REQ-015 o_mem_addr  output  32  word address, {addr[31:2],2'b00}.
REQ-016 o_mem_wdata  output  32  store data shifted left by 8*addr[1:0].
REQ-017 i_mem_gnt  input  1  memory accepts request when o_mem_req and i_mem_gnt both 1.
REQ-018 i_mem_rvalid  input  1  response valid, one per granted request (reads and writes).
REQ-019 i_mem_rdata  input  32  read data, valid with i_mem_rvalid.

Function
REQ-020 FSM states IDLE, REQ, WAIT, DONE; reset state IDLE.
REQ-021 IDLE: o_core_ready = NOT(i_core_rd_en OR i_core_wr_en); on a request, latch addr, wdata, size, direction and go REQ (legal) or DONE with error (illegal).
REQ-022 Illegal request: rd_en and wr_en both 1; size not in {0001,0011,1111}; half with addr[0]=1; word with addr[1:0]!=0; no memory transaction issued.
REQ-023 REQ: o_mem_req=1 and o_mem_we/be/addr/wdata driven from latched values, stable until grant; on i_mem_gnt go WAIT.
REQ-024 WAIT: o_mem_req=0; on i_mem_rvalid capture read data (reads only) and go DONE; i_mem_rvalid outside WAIT ignored.
REQ-025 DONE: o_core_ready=1 for exactly one cycle, o_core_err=1 if error, then IDLE unconditionally.
REQ-026 Read data: o_core_rdata = (i_mem_rdata >> 8*addr[1:0]) masked to access size; register updated only on a successful read, held otherwise; on read error it is set to 0.
REQ-027 Minimum latency: request seen in IDLE cycle N, grant in N+1, rvalid in N+2 -> o_core_ready=1 in N+3.
REQ-028 Timeout counter cleared on entry to REQ and WAIT, increments each cycle in those states; reaching TIMEOUT forces DONE with error, o_mem_req deasserted.
REQ-029 Response arriving after a timeout abort is ignored and does not update o_core_rdata.
REQ-030 Only one outstanding transaction; new core requests are not sampled outside IDLE.
REQ-031 Memory-side outputs other than o_mem_req are don't-care when o_mem_req=0 but shall hold latched values.

Reset
REQ-032 rst asserted forces, asynchronously and in any state: state IDLE, o_mem_req=0, o_mem_we=0, o_mem_be=0, o_mem_addr=0, o_mem_wdata=0, o_core_rdata=0, o_core_err=0, counter=0.
REQ-033 o_core_ready during/after reset follows REQ-021 (1 with no request pending).
REQ-034 Reset mid-transaction abandons it; any later i_mem_rvalid is ignored.

Verification
REQ-035 LW addr 0x100, memory grants immediately, rvalid next cycle, rdata 0xCAFEBABE -> o_mem_be=1111, o_mem_addr=0x100, o_core_ready 3 cycles after request, o_core_rdata=0xCAFEBABE, err=0.
REQ-036 SB addr 0x203, wdata 0x000000A5 -> o_mem_be=1000, o_mem_addr=0x200, o_mem_wdata[31:24]=0xA5, o_mem_we=1, ready after rvalid, err=0.
REQ-037 LH addr 0x102, rdata 0x1234ABCD -> o_mem_be=1100, o_core_rdata=0x00001234; then LW addr 0x101 -> no o_mem_req, ready+err next cycle, rdata=0.
REQ-038 Grant withheld 3 cycles, rvalid 5 cycles later -> o_mem_req held high with stable addr/be until grant; completion only after rvalid; exactly one ready pulse.
REQ-039 TIMEOUT=8, grant never given -> o_mem_req drops, ready+err pulse 9 cycles after request; late rvalid ignored, rdata unchanged.
REQ-040 rst pulsed while in WAIT -> o_mem_req=0 and state IDLE immediately (no clock edge), ready=1 with no request, subsequent rvalid ignored.
